pipelined_addsub: RTL and testbench
===================================

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, 2, pipeline depth (1..4); each stage resolves WIDTH/STAGES result bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 op_sub  input  1  0 = add, 1 = subtract; sampled with the operands.
REQ-008 operand_1  input  WIDTH  first operand.
REQ-009 operand_2  input  WIDTH  second operand.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 carry_out  output  1  add: carry out of MSB; sub: 1 = no borrow.
REQ-014 overflow  output  1  signed two's-complement overflow.
REQ-015 zero  output  1  result equals 0.

Function
REQ-016 Add SHALL compute operand_1 + operand_2 + 0; subtract SHALL compute operand_1 + ~operand_2 + 1.
REQ-017 Carry chain SHALL be split into STAGES slices; slice k carry-in SHALL be the registered carry of slice k-1; unresolved upper operand bits and resolved lower result bits SHALL be carried in skew registers.
REQ-018 Latency SHALL be exactly STAGES cycles from accepted beat (in_valid & in_ready) to out_valid, with no stalls.
REQ-019 Pipeline SHALL advance when advance = !out_valid | out_ready; in_ready SHALL equal advance (combinational).
REQ-020 Each stage SHALL hold a valid bit; a bubble (in_valid=0 on advance) SHALL propagate as valid=0.
REQ-021 When advance=0, all stage registers, result and flags SHALL hold their values unchanged.
REQ-022 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-023 overflow SHALL be 1 iff both effective addend MSBs are equal and result MSB differs (effective second addend is ~operand_2 for subtract).
REQ-024 zero, carry_out, overflow SHALL be registered with result and valid only when out_valid=1.
REQ-025 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated.
REQ-026 in_valid with in_ready=0 SHALL NOT be captured; the producer holds the beat.
REQ-027 Simultaneous result consumption and new acceptance in one cycle SHALL be supported without bubbles.

Reset
REQ-028 rst_n=0 SHALL immediately clear all stage valid bits, out_valid, result, carry_out, overflow, zero to 0, independent of clk.
REQ-029 Beats in flight at reset assertion SHALL be discarded.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 and the first accepting edge SHALL be the first rising edge with rst_n=1.

Verification
REQ-031 WIDTH=32, STAGES=2: add 0x0000_0004 + 0x0040_0000, out_ready=1 -> result 0x0040_0004, carry 0, ovf 0, zero 0, exactly 2 cycles later.
REQ-032 Add 0xFFFF_FFFF + 0x0000_0001 -> result 0, carry 1, zero 1, ovf 0; add 0x7FFF_FFFF + 1 -> 0x8000_0000, ovf 1, carry 0.
REQ-033 Subtract 5 - 7 -> 0xFFFF_FFFE, carry 0 (borrow); 7 - 5 -> 2, carry 1; 0x8000_0000 - 1 -> 0x7FFF_FFFF, ovf 1.
REQ-034 Stream 8 back-to-back beats with out_ready toggling 1,0,0,1,...: all 8 results delivered in order, values stable while out_valid=1 and out_ready=0, in_ready=0 exactly on stalled cycles.
REQ-035 Assert rst_n=0 mid-stream with 2 beats in flight -> out_valid and all flags 0 without a clock edge; no stale beat emerges after release.
REQ-036 Repeat REQ-031..REQ-033 for STAGES=1 (latency 1) and STAGES=4, WIDTH=16 (latency 4), checking against a reference model on 10,000 random beats.

Source files
------------

// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Add/subtract unit whose carry chain is cut into STAGES slices of
//   WIDTH/STAGES bits. Each pipeline stage resolves one slice. The operand
//   bits that are still unresolved move forward in skew registers that shrink
//   by one slice per stage. The result bits already resolved move forward in
//   skew registers that grow by one slice per stage. The final slice writes
//   the output registers directly, so the latency is exactly STAGES cycles.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = advance, combinational)
//   op_sub                0 = add, 1 = subtract (sampled with the operands)
//   operand_1, operand_2  WIDTH-bit operands
//   out_valid / out_ready result handshake
//   result                sum or difference, modulo 2^WIDTH
//   carry_out             carry out of the MSB (for subtract: 1 = no borrow)
//   overflow              signed two's-complement overflow
//   zero                  result == 0
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int SL = WIDTH / STAGES;  // bits resolved per stage
    localparam int L  = STAGES - 1;      // index of the last slice

    // The whole pipeline moves in lockstep. It stalls only when a result is
    // waiting and the consumer is not taking it.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : stg
        localparam int RW = WIDTH - k * SL;  // operand bits still unresolved

        // a_cur/b_cur: remaining operand bits, with slice k at the bottom.
        // b_cur is the effective addend (already inverted for subtract).
        logic [RW-1:0]         a_cur;
        logic [RW-1:0]         b_cur;
        logic                  c_cur;
        logic                  v_cur;
        logic [SL:0]           sum;
        logic [(k+1)*SL-1:0]   r_nxt;   // result bits resolved up to this slice

        if (k == 0) begin : g_in
            assign a_cur = operand_1;
            assign b_cur = op_sub ? ~operand_2 : operand_2;
            assign c_cur = op_sub;
            assign v_cur = in_valid;
            assign r_nxt = sum[SL-1:0];
        end else begin : g_reg
            logic [RW-1:0]     a_q;
            logic [RW-1:0]     b_q;
            logic [k*SL-1:0]   r_q;
            logic              c_q;
            logic              v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    r_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (advance) begin
                    a_q <= stg[k-1].a_cur[RW+SL-1:SL];
                    b_q <= stg[k-1].b_cur[RW+SL-1:SL];
                    r_q <= stg[k-1].r_nxt;
                    c_q <= stg[k-1].sum[SL];
                    v_q <= stg[k-1].v_cur;
                end
            end

            assign a_cur = a_q;
            assign b_cur = b_q;
            assign c_cur = c_q;
            assign v_cur = v_q;
            assign r_nxt = {sum[SL-1:0], r_q};
        end

        assign sum = {1'b0, a_cur[SL-1:0]} + {1'b0, b_cur[SL-1:0]} + {{SL{1'b0}}, c_cur};
    end

    // Final slice completes the word. At this point the top bits of the
    // skewed operands are the MSBs of the effective addends.
    logic [WIDTH-1:0] res_nxt;
    logic             a_msb;
    logic             b_msb;
    logic             ovf_nxt;

    assign res_nxt = stg[L].r_nxt;
    assign a_msb   = stg[L].a_cur[SL-1];
    assign b_msb   = stg[L].b_cur[SL-1];
    assign ovf_nxt = (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= stg[L].v_cur;
            result    <= res_nxt;
            carry_out <= stg[L].sum[SL];
            overflow  <= ovf_nxt;
            zero      <= (res_nxt == '0);
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub
//   Three instances: 32/2, 32/1 and 16/4 (WIDTH/STAGES).
//   Accepted beats are pushed to a per-instance scoreboard. The expected value
//   comes from a full-width reference add. Delivered beats are popped and
//   compared. Stalled outputs must hold their values.
module tb_pipelined_addsub;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  f;   // {carry, overflow, zero}
        int          t;   // cycle at which the beat was offered and accepted
    } exp_t;

    localparam int ST[3] = '{2, 1, 4};
    localparam int WD[3] = '{32, 32, 16};

    localparam int NV = 9;
    localparam logic        TV_S[NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] TV_A[NV] = '{32'h0000_0004, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                         32'h0000_0005, 32'h0000_0007, 32'h8000_0000,
                                         32'h0000_FFFF, 32'h0000_7FFF, 32'h0000_8000};
    localparam logic [31:0] TV_B[NV] = '{32'h0040_0000, 32'h0000_0001, 32'h0000_0001,
                                         32'h0000_0007, 32'h0000_0005, 32'h0000_0001,
                                         32'h0000_0001, 32'h0000_0001, 32'h0000_0001};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid, op_sub, out_ready;
    logic [31:0] op1 [3];
    logic [31:0] op2 [3];
    wire  [2:0]  in_ready, out_valid, carry_out, overflow, zero;
    wire  [31:0] res0, res1;
    wire  [15:0] res2;

    int   n_run = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_mode;
    bit   [2:0] done;
    exp_t sbq [3][$];
    bit          prev_stall [3];
    logic [31:0] prev_res [3];
    logic [2:0]  prev_f [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub #(.WIDTH(32), .STAGES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op_sub(op_sub[0]), .operand_1(op1[0]), .operand_2(op2[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(res0),
        .carry_out(carry_out[0]), .overflow(overflow[0]), .zero(zero[0]));

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op_sub(op_sub[1]), .operand_1(op1[1]), .operand_2(op2[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(res1),
        .carry_out(carry_out[1]), .overflow(overflow[1]), .zero(zero[1]));

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .op_sub(op_sub[2]), .operand_1(op1[2][15:0]), .operand_2(op2[2][15:0]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .result(res2),
        .carry_out(carry_out[2]), .overflow(overflow[2]), .zero(zero[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_res(input int d);
        case (d)
            0:       return res0;
            1:       return res1;
            default: return {16'h0, res2};
        endcase
    endfunction

    // Reference: one full-width add of a + (sub ? ~b : b) + sub.
    function automatic exp_t model(input int w, input logic sub, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] mask, aa, bb, s;
        mask = (33'd1 << w) - 33'd1;
        aa   = {1'b0, a} & mask;
        bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        s    = aa + bb + {32'd0, sub};
        e.r  = s[31:0] & mask[31:0];
        e.f[2] = s[w];
        e.f[1] = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        e.f[0] = (e.r == 32'd0);
        e.t  = 0;
        return e;
    endfunction

    // Monitor: sample in the middle of the cycle. The handshake seen here is
    // the one that completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) prev_stall[d] <= 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                logic [31:0] r;
                logic [2:0]  f;
                exp_t        e;
                r = get_res(d);
                f = {carry_out[d], overflow[d], zero[d]};
                chk($sformatf("in_ready%0d", d), {31'd0, in_ready[d]}, {31'd0, !out_valid[d] || out_ready[d]});
                if (prev_stall[d]) begin
                    chk($sformatf("hold_valid%0d", d), {31'd0, out_valid[d]}, 32'd1);
                    chk($sformatf("hold_res%0d", d), r, prev_res[d]);
                    chk($sformatf("hold_flags%0d", d), {29'd0, f}, {29'd0, prev_f[d]});
                end
                if (out_valid[d] && out_ready[d]) begin
                    chk($sformatf("sb_nonempty%0d", d), {31'd0, sbq[d].size() != 0}, 32'd1);
                    if (sbq[d].size() != 0) begin
                        e = sbq[d].pop_front();
                        chk($sformatf("result%0d", d), r, e.r);
                        chk($sformatf("flags%0d", d), {29'd0, f}, {29'd0, e.f});
                        if (lat_mode) chk($sformatf("latency%0d", d), cyc - e.t, ST[d]);
                    end
                end
                if (in_valid[d] && in_ready[d]) begin
                    e   = model(WD[d], op_sub[d], op1[d], op2[d]);
                    e.t = cyc;
                    sbq[d].push_back(e);
                end
                prev_stall[d] <= out_valid[d] && !out_ready[d];
                prev_res[d]   <= r;
                prev_f[d]     <= f;
            end
        end
    end

    // Offer one beat and hold it until it is accepted. Returns just after the accepting edge.
    task automatic send(input int d, input logic sub, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        in_valid[d] = 1'b1;
        op_sub[d]   = sub;
        op1[d]      = a;
        op2[d]      = b;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready[d]) ok = 1'b1;
        end
        chk($sformatf("send_accept%0d", d), {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic directed(input int d);
        lat_mode     = 1'b1;
        out_ready[d] = 1'b1;
        for (int i = 0; i < NV; i++) send(d, TV_S[i], TV_A[i], TV_B[i]);
        in_valid[d] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        lat_mode = 1'b0;
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(9))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_7FFF;
            5:       return 32'h0000_8000;
            6:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_run(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(7) == 0) begin
                in_valid[d] = 1'b0;
                @(posedge clk); #1;
            end
            send(d, 1'($urandom_range(1)), rval(), rval());
        end
        in_valid[d] = 1'b0;
        done[d] = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        op_sub    = '0;
        out_ready = '1;
        lat_mode  = 1'b0;
        done      = '0;
        for (int d = 0; d < 3; d++) begin
            op1[d] = '0;
            op2[d] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid%0d", d), {31'd0, out_valid[d]}, 32'd0);
            chk($sformatf("rst_res%0d", d), get_res(d), 32'd0);
            chk($sformatf("rst_flags%0d", d), {29'd0, carry_out[d], overflow[d], zero[d]}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) chk($sformatf("rel_in_ready%0d", d), {31'd0, in_ready[d]}, 32'd1);

        // Directed corner vectors with exact latency, every configuration
        for (int d = 0; d < 3; d++) directed(d);

        // Back-to-back stream with out_ready pattern 1,0,0,1
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(0, 1'(i % 2), 32'h1357_0000 + 32'(i * 32'h1111), 32'(i * 3));
                in_valid[0] = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready[0] = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("stream_drained", sbq[0].size(), 32'd0);

        // Reset with two beats in flight
        send(0, 1'b0, 32'h1111_1111, 32'h2222_2222);
        send(0, 1'b1, 32'h3333_3333, 32'h0000_0001);
        in_valid[0] = 1'b0;
        #1;
        chk("pre_rst_valid", {31'd0, out_valid[0]}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("async_rst_res", res0, 32'd0);
        chk("async_rst_flags", {29'd0, carry_out[0], overflow[0], zero[0]}, 32'd0);
        for (int d = 0; d < 3; d++) sbq[d].delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_no_stale", {31'd0, out_valid[0]}, 32'd0);
        end
        @(posedge clk); #1;

        // Random streams on all three configurations with random backpressure
        fork
            rand_run(0, 2000);
            rand_run(1, 10000);
            rand_run(2, 10000);
            begin
                for (int c = 0; c < 60000 && done != 3'b111; c++) begin
                    for (int d = 0; d < 3; d++) out_ready[d] = ($urandom_range(3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = '1;
        repeat (10) @(posedge clk);
        #1;
        chk("rand_done", {29'd0, done}, 32'd7);
        for (int d = 0; d < 3; d++) chk($sformatf("sb_drained%0d", d), sbq[d].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
